// File: rtl/load_unit.sv
// load_unit: single-request load pipeline stage between dispatch and a word-wide memory.
//   Accepts one load per handshake and computes addr = in_base + in_imm.
//   Reads the word or words that hold the addressed bytes.
//   Returns the extracted, sign- or zero-extended result on a valid/ready writeback port.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake; in_op, in_base, in_imm, in_rd carry the request
//   mem_req/mem_addr       word read request (address always word aligned)
//   mem_ack/mem_rdata      read completion, data valid in the ack cycle
//   wb_valid/wb_ready      result handshake; wb_rd, wb_data, wb_err carry the result
//
// Optional feature macro: LOAD_MISALIGN_EN
//   defined   -> loads crossing a word boundary are split into two word reads
//   undefined -> any misaligned LW/LH/LHU completes immediately with wb_err=1

`ifndef LOAD_UNIT_OPS_DEFINED
`define LOAD_UNIT_OPS_DEFINED
`define OPER_T logic [3:0]
`define OP_LB  4'd0
`define OP_LH  4'd1
`define OP_LW  4'd2
`define OP_LBU 4'd4
`define OP_LHU 4'd5
`endif

module load_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  `OPER_T       in_op,
  input  logic [31:0]  in_base,
  input  logic [31:0]  in_imm,
  input  logic [4:0]   in_rd,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [4:0]   wb_rd,
  output logic [31:0]  wb_data,
  output logic         wb_err
);

  typedef enum logic [1:0] {IDLE, REQ0, REQ1, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_err_q, wb_err_d;
  logic        ready_q;
`ifdef LOAD_MISALIGN_EN
  logic [31:0] word0_q, word0_d;
  logic        split;
`else
  logic        misalign;
`endif

  logic [31:0] acc_addr;
  logic        accept;
  logic [31:0] word_addr;

  function automatic logic is_load(input logic [3:0] op);
    return (op == `OP_LB) || (op == `OP_LH) || (op == `OP_LW) ||
           (op == `OP_LBU) || (op == `OP_LHU);
  endfunction

  // Little-endian extraction from the 64-bit pair {w1, w0} at byte offset off.
  function automatic logic [31:0] extract(input logic [3:0] op, input logic [1:0] off,
                                          input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] dw;
    logic [31:0] r;
    dw = {w1, w0} >> {off, 3'b000};
    case (op)
      `OP_LB:  r = {{24{dw[7]}}, dw[7:0]};
      `OP_LBU: r = {24'h000000, dw[7:0]};
      `OP_LH:  r = {{16{dw[15]}}, dw[15:0]};
      `OP_LHU: r = {16'h0000, dw[15:0]};
      default: r = dw[31:0];
    endcase
    return r;
  endfunction

  assign acc_addr  = in_base + in_imm;
  assign accept    = in_valid && in_ready;
  assign word_addr = {addr_q[31:2], 2'b00};

`ifdef LOAD_MISALIGN_EN
  assign split = ((op_q == `OP_LW) && (addr_q[1:0] != 2'b00)) ||
                 (((op_q == `OP_LH) || (op_q == `OP_LHU)) && (addr_q[1:0] == 2'b11));
`else
  assign misalign = ((in_op == `OP_LW) && (acc_addr[1:0] != 2'b00)) ||
                    (((in_op == `OP_LH) || (in_op == `OP_LHU)) && acc_addr[0]);
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
`ifdef LOAD_MISALIGN_EN
    word0_d   = word0_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = in_op;
          rd_d   = in_rd;
          addr_d = acc_addr;
`ifdef LOAD_MISALIGN_EN
          if (!is_load(in_op)) begin
`else
          if (!is_load(in_op) || misalign) begin
`endif
            wb_err_d  = 1'b1;
            wb_data_d = '0;
            state_d   = RESP;
          end else begin
            state_d = REQ0;
          end
        end
      end
      REQ0: begin
        if (mem_ack) begin
`ifdef LOAD_MISALIGN_EN
          if (split) begin
            word0_d = mem_rdata;
            state_d = REQ1;
          end else
`endif
          begin
            wb_data_d = extract(op_q, addr_q[1:0], mem_rdata, '0);
            wb_err_d  = 1'b0;
            state_d   = RESP;
          end
        end
      end
`ifdef LOAD_MISALIGN_EN
      REQ1: begin
        if (mem_ack) begin
          wb_data_d = extract(op_q, addr_q[1:0], word0_q, mem_rdata);
          wb_err_d  = 1'b0;
          state_d   = RESP;
        end
      end
`endif
      RESP: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
      ready_q   <= 1'b0;
`ifdef LOAD_MISALIGN_EN
      word0_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
      ready_q   <= 1'b1;
`ifdef LOAD_MISALIGN_EN
      word0_q   <= word0_d;
`endif
    end
  end

  // ready_q delays in_ready by one cycle after reset release; rst gates all outputs low.
  always_comb begin
    in_ready = !rst && ready_q && (state_q == IDLE);
    mem_req  = !rst && ((state_q == REQ0) || (state_q == REQ1));
    mem_addr = '0;
    if (!rst) begin
      if (state_q == REQ0) mem_addr = word_addr;
      else if (state_q == REQ1) mem_addr = word_addr + 32'd4;
    end
    wb_valid = !rst && (state_q == RESP);
    wb_rd    = wb_valid ? rd_q : '0;
    wb_data  = wb_valid ? wb_data_q : '0;
    wb_err   = wb_valid ? wb_err_q : 1'b0;
  end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed self-checking bench for load_unit.
// Inputs change and outputs are sampled on the falling clock edge.
// Build with or without LOAD_MISALIGN_EN; the misaligned-access expectations follow the macro.

module tb_load_unit;

  localparam logic [3:0] LB  = 4'd0;
  localparam logic [3:0] LH  = 4'd1;
  localparam logic [3:0] LW  = 4'd2;
  localparam logic [3:0] LBU = 4'd4;
  localparam logic [3:0] LHU = 4'd5;
  localparam logic [3:0] ADD = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_base(in_base), .in_imm(in_imm), .in_rd(in_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] base,
                     input logic [31:0] imm, input logic [4:0] rd);
    in_op = op; in_base = base; in_imm = imm; in_rd = rd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d);
    mem_ack = 1'b1; mem_rdata = d;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic take();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_base = '0; in_imm = '0; in_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_err", wb_err, 1'b0);

    // request offered while rst falls must not be taken; in_ready rises one cycle later
    rst = 1'b0; in_valid = 1'b1; in_op = LW; in_base = 32'h40; in_rd = 5'd1;
    #1 chk("rel_in_ready_low", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("rel_in_ready_high", in_ready, 1'b1);
    chk("rel_no_req", mem_req, 1'b0);

    // LB addr 0xFF, zero-wait memory
    req(LB, 32'h100, 32'hFFFF_FFFF, 5'd5);
    chk("lb_mem_req", mem_req, 1'b1);
    chk("lb_mem_addr", mem_addr, 32'h0000_00FC);
    chk("lb_in_ready", in_ready, 1'b0);
    chk("lb_wb_valid_early", wb_valid, 1'b0);
    ack(32'h8011_2233);
    chk("lb_mem_req_drop", mem_req, 1'b0);
    chk("lb_wb_valid", wb_valid, 1'b1);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_err", wb_err, 1'b0);
    chk("lb_wb_rd", wb_rd, 5'd5);
    take();
    chk("lb_idle_ready", in_ready, 1'b1);
    chk("lb_idle_wb_valid", wb_valid, 1'b0);

    // LHU / LH at 0x202
    req(LHU, 32'h200, 32'h2, 5'd7);
    chk("lhu_mem_addr", mem_addr, 32'h0000_0200);
    ack(32'hBEEF_1234);
    chk("lhu_wb_data", wb_data, 32'h0000_BEEF);
    take();
    req(LH, 32'h200, 32'h2, 5'd7);
    ack(32'hBEEF_1234);
    chk("lh_wb_data", wb_data, 32'hFFFF_BEEF);
    take();

    // LW at 0x1FE
    req(LW, 32'h1F0, 32'hE, 5'd8);
`ifdef LOAD_MISALIGN_EN
    chk("lws_req0", mem_req, 1'b1);
    chk("lws_addr0", mem_addr, 32'h0000_01FC);
    ack(32'hAABB_CCDD);
    chk("lws_req1", mem_req, 1'b1);
    chk("lws_addr1", mem_addr, 32'h0000_0200);
    chk("lws_wb_valid_early", wb_valid, 1'b0);
    ack(32'h1122_3344);
    chk("lws_mem_req_drop", mem_req, 1'b0);
    chk("lws_wb_data", wb_data, 32'h3344_AABB);
    chk("lws_wb_err", wb_err, 1'b0);
`else
    chk("lwm_no_req", mem_req, 1'b0);
    chk("lwm_wb_valid", wb_valid, 1'b1);
    chk("lwm_wb_err", wb_err, 1'b1);
    chk("lwm_wb_data", wb_data, 32'h0);
    chk("lwm_wb_rd", wb_rd, 5'd8);
`endif
    take();

    // LH at 0x201: inside one word when splitting is enabled, misaligned otherwise
    req(LH, 32'h200, 32'h1, 5'd9);
`ifdef LOAD_MISALIGN_EN
    chk("lh1_mem_addr", mem_addr, 32'h0000_0200);
    ack(32'hBEEF_1234);
    chk("lh1_wb_data", wb_data, 32'hFFFF_EF12);
`else
    chk("lh1_no_req", mem_req, 1'b0);
    chk("lh1_wb_err", wb_err, 1'b1);
`endif
    take();

`ifdef LOAD_MISALIGN_EN
    // LHU at 0x203 crosses into the next word
    req(LHU, 32'h200, 32'h3, 5'd10);
    ack(32'hBEEF_1234);
    chk("lhu3_addr1", mem_addr, 32'h0000_0204);
    ack(32'h0000_00AB);
    chk("lhu3_wb_data", wb_data, 32'h0000_ABBE);
    take();

    // LW at 0xFFFFFFFF wraps to address 0
    req(LW, 32'hFFFF_FFF0, 32'hF, 5'd11);
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    ack(32'h4433_2211);
    chk("wrap_addr1", mem_addr, 32'h0000_0000);
    chk("wrap_req1", mem_req, 1'b1);
    ack(32'h8877_6655);
    chk("wrap_wb_data", wb_data, 32'h7766_5544);
    take();
`endif

    // non-load op: immediate fault, no memory access
    req(ADD, 32'h10, 32'h4, 5'd12);
    chk("nl_no_req", mem_req, 1'b0);
    chk("nl_wb_valid", wb_valid, 1'b1);
    chk("nl_wb_err", wb_err, 1'b1);
    chk("nl_wb_data", wb_data, 32'h0);
    chk("nl_wb_rd", wb_rd, 5'd12);
    take();

    // stalls: ack after 3 wait cycles, wb_ready after 2 wait cycles
    req(LW, 32'h40, 32'h0, 5'd13);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("st_mem_req", mem_req, 1'b1);
      chk("st_mem_addr", mem_addr, 32'h0000_0040);
      tick();
    end
    ack(32'hDEAD_BEEF);
    for (int unsigned i = 0; i < 2; i++) begin
      chk("st_wb_valid", wb_valid, 1'b1);
      chk("st_wb_data", wb_data, 32'hDEAD_BEEF);
      chk("st_wb_rd", wb_rd, 5'd13);
      chk("st_in_ready", in_ready, 1'b0);
      tick();
    end
    wb_ready = 1'b1;
    #1 chk("st_in_ready_hs", in_ready, 1'b0);
    tick();
    wb_ready = 1'b0;
    chk("st_in_ready_after", in_ready, 1'b1);
    chk("st_wb_valid_after", wb_valid, 1'b0);

    // rd=0 completes normally
    req(LBU, 32'h0, 32'h3, 5'd0);
    ack(32'h8011_2233);
    chk("rd0_wb_valid", wb_valid, 1'b1);
    chk("rd0_wb_data", wb_data, 32'h0000_0080);
    chk("rd0_wb_rd", wb_rd, 5'd0);
    take();

    // reset during REQ0, late ack must be dropped
    req(LW, 32'h80, 32'h0, 5'd14);
    chk("ra_mem_req", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("ra_mem_req_rst", mem_req, 1'b0);
    chk("ra_in_ready_rst", in_ready, 1'b0);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("ra_no_wb", wb_valid, 1'b0);
    chk("ra_no_req", mem_req, 1'b0);
    chk("ra_in_ready", in_ready, 1'b1);
    req(LW, 32'h0, 32'h0, 5'd3);
    chk("ra_new_addr", mem_addr, 32'h0);
    ack(32'hCAFE_F00D);
    chk("ra_new_wb_data", wb_data, 32'hCAFE_F00D);
    chk("ra_new_wb_rd", wb_rd, 5'd3);
    chk("ra_new_wb_err", wb_err, 1'b0);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 SHALL provide in_valid  input  1  load request from dispatch.
REQ-003 SHALL provide in_ready  output  1  unit can accept a request.
REQ-004 SHALL provide in_op  input  `oper_t  operation code; loads are OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU.
REQ-005 SHALL provide in_base  input  32  rs1 value.
REQ-006 SHALL provide in_imm  input  32  sign-extended offset.
REQ-007 SHALL provide in_rd  input  5  destination register.
REQ-008 SHALL provide mem_req  output  1  word read request.
REQ-009 SHALL provide mem_addr  output  32  word address; bits [1:0] always 0.
REQ-010 SHALL provide mem_ack  input  1  read done; mem_rdata valid in the same cycle.
REQ-011 SHALL provide mem_rdata  input  32  little-endian read word.
REQ-012 SHALL provide wb_valid  output  1  result available.
REQ-013 SHALL provide wb_ready  input  1  writeback consumer accepts.
REQ-014 SHALL provide wb_rd  output  5  destination register.
REQ-015 SHALL provide wb_data  output  32  extended load result.
REQ-016 SHALL provide wb_err  output  1  result is a fault, not data.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ0, REQ1, RESP.
REQ-018 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid and in_ready are both high, and op, rd and addr=(in_base+in_imm) mod 2^32 are latched.
REQ-019 On accept, SHALL go to REQ0 next cycle for a valid load; SHALL go straight to RESP with wb_err=1 and wb_data=0, with no memory access, for a non-load op.
REQ-020 In REQ0, SHALL hold mem_req=1 and mem_addr={addr[31:2],2'b00} stable until the mem_ack cycle; an ack in the first REQ0 cycle is legal.
REQ-021 A split access SHALL be LW with addr[1:0]!=0, or LH/LHU with addr[1:0]==3; on REQ0 ack a split SHALL capture word0 and go to REQ1, otherwise go to RESP.
REQ-022 In REQ1, SHALL drive mem_req=1 with mem_addr=word0 address+4 mod 2^32 (0xFFFFFFFC wraps to 0x00000000) and go to RESP on ack.
REQ-023 SHALL drive mem_req=0 outside REQ0/REQ1 and SHALL deassert it in the cycle after ack.
REQ-024 SHALL extract bytes at offset addr[1:0] from {word1,word0} (little-endian); LB/LH sign-extend, LBU/LHU zero-extend, LW takes 32 bits.
REQ-025 In RESP, SHALL hold wb_valid=1 and wb_rd/wb_data/wb_err stable until wb_ready; on the ready cycle go to IDLE; the next request is acceptable the following cycle.
REQ-026 SHALL give aligned-load latency accept->wb_valid = 1 + ack-wait + 1 cycles; with zero-wait memory, wb_valid is high 2 cycles after accept, and 3 cycles for a split.
REQ-027 SHALL still complete a load with rd=0 normally; suppression is the register file's job.

Reset
REQ-028 While rst=1, SHALL force state to IDLE and outputs to in_ready=0, mem_req=0, mem_addr=0, wb_valid=0, wb_rd=0, wb_data=0, wb_err=0; in_ready rises the cycle after rst falls.
REQ-029 Reset asserted mid-access SHALL abandon the access (mem_req low at the next edge) and discard any late mem_ack.

Configuration
REQ-030 With LOAD_MISALIGN_EN defined, split accesses SHALL be performed per REQ-021/022.
REQ-031 Without LOAD_MISALIGN_EN, any misaligned load (LW with addr[1:0]!=0; LH/LHU with addr[0]=1) SHALL go directly to RESP with wb_err=1 and wb_data=0, with no memory access; REQ1 logic SHALL be absent.

Verification
REQ-032 LB: base=0x100, imm=-1 (addr 0xFF), word@0xFC=0x80112233, zero-wait memory -> mem_addr=0xFC; wb_data=0xFFFFFF80, wb_err=0, wb_valid 2 cycles after accept.
REQ-033 LHU: addr 0x202, word@0x200=0xBEEF1234 -> wb_data=0x0000BEEF; LH at the same address -> wb_data=0xFFFFBEEF.
REQ-034 LW at addr 0x1FE with macro on: word@0x1FC=0xAABBCCDD, word@0x200=0x11223344 -> two requests (0x1FC, 0x200), wb_data=0x3344AABB; with macro off -> no mem_req, wb_err=1, wb_data=0.
REQ-035 LW wrap: addr 0xFFFFFFFF with macro on -> requests to 0xFFFFFFFC then 0x00000000.
REQ-036 Stalls: mem_ack delayed 3 cycles and wb_ready delayed 2 cycles -> mem_req/mem_addr and wb outputs stay stable, and in_ready stays 0 until the cycle after the wb handshake.
REQ-037 Reset during REQ0 with ack 1 cycle later -> mem_req=0 next edge, no wb_valid, and a new LW to 0x0 completes correctly.
